string_op_seq: RTL and testbench
================================

Name: string_op_seq

Overview:
- Multi-cycle sequencer for x86 string instructions: MOVS and STOS, with or without the REP prefix.
- Sits in the execute stage beside the alu2 pointer datapath and owns the memory request/ack handshakes for each iteration.
- Applies the DF-directed ESI/EDI step and decrements ECX each iteration.
- Stalls the pipeline while busy and hands final register values to writeback.

Parameters:
- ADDR_W, 32, width of ESI/EDI/ECX and memory addresses
- DATA_W, 32, width of memory data and EAX

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- start  input  1  launch pulse; sampled only in IDLE
- is_movs  input  1  1 = MOVS, 0 = STOS
- rep_en  input  1  REP prefix present
- op_size  input  2  00 byte, 01 word, 10 dword; 11 treated as dword
- DF_in  input  1  direction flag: 0 increment, 1 decrement
- ecx_in, esi_in, edi_in  input  ADDR_W  initial register values
- eax_in  input  DATA_W  STOS source data
- flush  input  1  pipeline flush/abort
- mem_rd_req  output  1  read request
- mem_rd_addr  output  ADDR_W  read address (=ESI)
- mem_rd_ack  input  1  read accepted; data valid on mem_rd_data
- mem_rd_data  input  DATA_W  read data
- mem_wr_req  output  1  write request
- mem_wr_addr  output  ADDR_W  write address (=EDI)
- mem_wr_data  output  DATA_W  write data
- mem_wr_ack  input  1  write accepted
- mem_size  output  2  latched op_size, valid while any request is high
- busy  output  1  state != IDLE; used as pipeline stall
- done  output  1  one-cycle completion pulse
- ecx_out, esi_out, edi_out  output  ADDR_W  final values; valid when done=1

Behaviour:
- States: IDLE, READ, WRITE, UPDATE, DONE.
- Reset: state = IDLE. All outputs are 0: reqs, busy, done, addresses, data, mem_size, ecx/esi/edi_out.
- Launch (IDLE, start=1):
  - Latch is_movs, rep_en, size, DF, ECX, ESI, EDI, EAX.
  - Next state: DONE if rep_en=1 and ECX=0 (no memory access); else READ if MOVS; else WRITE.
- start while busy is ignored.
- READ:
  - mem_rd_req=1, addr=ESI.
  - Hold until mem_rd_ack. Ack in the same cycle as req counts.
  - On ack, latch mem_rd_data and go to WRITE.
- WRITE:
  - mem_wr_req=1, addr=EDI.
  - Data = latched read data (MOVS) or EAX (STOS), full width; the sink honours mem_size.
  - On mem_wr_ack go to UPDATE.
- UPDATE (single cycle):
  - step = 1/2/4 by size.
  - EDI ±= step; ESI ±= step for MOVS only. Minus when DF=1.
  - If rep_en: ECX -= 1.
  - If rep_en and the new ECX != 0, go to READ/WRITE; else go to DONE.
- DONE: done=1 and outputs hold the latched ECX/ESI/EDI. Next state IDLE.
- Arithmetic: pointers wrap modulo 2^ADDR_W (0x00000000 − 4 = 0xFFFFFFFC). ECX is never decremented below 0.
- Latency with same-cycle acks (start at cycle 0):
  - non-REP STOS: done at cycle 3
  - non-REP MOVS: done at cycle 4
  - REP with ECX=N>0: done at 1 + N·(2 for STOS, 3 for MOVS) + 1 − 1, i.e. cycle N·k+1 where k = 2 or 3
  - REP with ECX=0: done at cycle 1
- Each extra ack-wait cycle adds one cycle.
- flush (any non-IDLE state):
  - Next state IDLE; requests drop the next cycle; no done pulse.
  - Updates from the flushed iteration are discarded.
  - flush in IDLE has no effect, and flush has priority over start.
- Requests never drop before their ack except on flush or rst.
- rst mid-operation: immediate return to IDLE; outputs are 0.

Decomposition:
- Shared package (string_op_pkg):
  - state enum
  - size codes SZ_BYTE/SZ_WORD/SZ_DWORD
  - step_of(size) function
- Sub-module str_ptr_step: combinational ptr ± step given size and DF. Instantiated twice (ESI, EDI).

Test Plan:
- STOS non-REP, size=10, DF=0, EDI=0x1000, EAX=0xDEADBEEF, immediate acks → one write to 0x1000 with data 0xDEADBEEF; done at cycle 3; edi_out=0x1004.
- REP MOVS, size=01, DF=1, ECX=3, ESI=0x2006, EDI=0x3006 → reads at 0x2006/0x2004/0x2002 and writes at 0x3006/0x3004/0x3002; done at cycle 10; ecx_out=0, esi_out=0x2000, edi_out=0x3000.
- REP STOS with ECX=0 → no mem_wr_req ever; done at cycle 1; outputs equal inputs.
- MOVS with mem_rd_ack delayed 2 cycles and mem_wr_ack delayed 1 → mem_rd_req and mem_wr_req held stable with constant address; done at cycle 7.
- REP MOVS byte, ECX=5; flush asserted during the 2nd WRITE → IDLE next cycle; no done; busy=0; a following start is accepted.
- Wrap: STOS dword, DF=1, EDI=0x00000002 → edi_out=0xFFFFFFFE. Also assert rst mid-READ → all outputs 0 asynchronously.

Source files
------------

// File: rtl/string_op_pkg.sv
// Shared types and helpers for the x86 string-instruction sequencer.
package string_op_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_UPDATE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_WORD  = 2'b01;
  localparam logic [1:0] SZ_DWORD = 2'b10;

  // Reserved size code 11 behaves as a dword.
  function automatic logic [2:0] step_of(input logic [1:0] size);
    logic [2:0] step;
    case (size)
      SZ_BYTE: step = 3'd1;
      SZ_WORD: step = 3'd2;
      default: step = 3'd4;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/str_ptr_step.sv
// Combinational ESI/EDI stepper: ptr +/- operand size, wrapping modulo 2^ADDR_W.
module str_ptr_step
  import string_op_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] ptr,
  input  logic [1:0]        size,
  input  logic              df,
  output logic [ADDR_W-1:0] result
);

  logic [ADDR_W-1:0] step_s;

  // DF=1 walks the string downwards
  always_comb begin
    step_s = {{(ADDR_W-3){1'b0}}, step_of(size)};
    if (df) begin
      result = ptr - step_s;
    end else begin
      result = ptr + step_s;
    end
  end

endmodule

// File: rtl/string_op_seq.sv
// MOVS/STOS (optionally REP) sequencer: one read/write handshake pair per
// iteration, pointer stepping by DF, ECX countdown, registered outputs.
module string_op_seq
  import string_op_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_movs,
  input  logic              rep_en,
  input  logic [1:0]        op_size,
  input  logic              DF_in,
  input  logic [ADDR_W-1:0] ecx_in,
  input  logic [ADDR_W-1:0] esi_in,
  input  logic [ADDR_W-1:0] edi_in,
  input  logic [DATA_W-1:0] eax_in,
  input  logic              flush,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_ack,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_wr_ack,
  output logic [1:0]        mem_size,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ecx_out,
  output logic [ADDR_W-1:0] esi_out,
  output logic [ADDR_W-1:0] edi_out
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_r, state_nxt_s;
  logic              is_movs_r, is_movs_nxt_s;
  logic              rep_r, rep_nxt_s;
  logic              df_r, df_nxt_s;
  logic [1:0]        size_r, size_nxt_s;
  logic [ADDR_W-1:0] ecx_r, ecx_nxt_s;
  logic [ADDR_W-1:0] esi_r, esi_nxt_s;
  logic [ADDR_W-1:0] edi_r, edi_nxt_s;
  logic [DATA_W-1:0] eax_r, eax_nxt_s;
  logic [DATA_W-1:0] rd_data_r, rd_data_nxt_s;
  logic [ADDR_W-1:0] esi_step_s, edi_step_s;

  str_ptr_step #(.ADDR_W(ADDR_W)) u_esi_step (
    .ptr(esi_r), .size(size_r), .df(df_r), .result(esi_step_s)
  );

  str_ptr_step #(.ADDR_W(ADDR_W)) u_edi_step (
    .ptr(edi_r), .size(size_r), .df(df_r), .result(edi_step_s)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and next datapath values; a flush leaves the datapath untouched
  always_comb begin
    state_nxt_s   = state_r;
    is_movs_nxt_s = is_movs_r;
    rep_nxt_s     = rep_r;
    df_nxt_s      = df_r;
    size_nxt_s    = size_r;
    ecx_nxt_s     = ecx_r;
    esi_nxt_s     = esi_r;
    edi_nxt_s     = edi_r;
    eax_nxt_s     = eax_r;
    rd_data_nxt_s = rd_data_r;
    if (flush && (state_r != ST_IDLE)) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            is_movs_nxt_s = is_movs;
            rep_nxt_s     = rep_en;
            df_nxt_s      = DF_in;
            size_nxt_s    = op_size;
            ecx_nxt_s     = ecx_in;
            esi_nxt_s     = esi_in;
            edi_nxt_s     = edi_in;
            eax_nxt_s     = eax_in;
            if (rep_en && (ecx_in == ADDR_ZERO)) begin
              state_nxt_s = ST_DONE;
            end else if (is_movs) begin
              state_nxt_s = ST_READ;
            end else begin
              state_nxt_s = ST_WRITE;
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_READ: begin
          if (mem_rd_ack) begin
            rd_data_nxt_s = mem_rd_data;
            state_nxt_s   = ST_WRITE;
          end else begin
            state_nxt_s = ST_READ;
          end
        end
        ST_WRITE: begin
          if (mem_wr_ack) begin
            state_nxt_s = ST_UPDATE;
          end else begin
            state_nxt_s = ST_WRITE;
          end
        end
        ST_UPDATE: begin
          edi_nxt_s = edi_step_s;
          if (is_movs_r) begin
            esi_nxt_s = esi_step_s;
          end else begin
            esi_nxt_s = esi_r;
          end
          if (rep_r && (ecx_r != ADDR_ZERO)) begin
            ecx_nxt_s = ecx_r - ADDR_ONE;
          end else begin
            ecx_nxt_s = ecx_r;
          end
          if (rep_r && (ecx_nxt_s != ADDR_ZERO)) begin
            if (is_movs_r) begin
              state_nxt_s = ST_READ;
            end else begin
              state_nxt_s = ST_WRITE;
            end
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        ST_DONE: state_nxt_s = ST_IDLE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Datapath latches plus outputs decoded one cycle ahead from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_movs_r   <= 1'b0;
      rep_r       <= 1'b0;
      df_r        <= 1'b0;
      size_r      <= 2'b00;
      ecx_r       <= ADDR_ZERO;
      esi_r       <= ADDR_ZERO;
      edi_r       <= ADDR_ZERO;
      eax_r       <= {DATA_W{1'b0}};
      rd_data_r   <= {DATA_W{1'b0}};
      mem_rd_req  <= 1'b0;
      mem_rd_addr <= ADDR_ZERO;
      mem_wr_req  <= 1'b0;
      mem_wr_addr <= ADDR_ZERO;
      mem_wr_data <= {DATA_W{1'b0}};
      mem_size    <= 2'b00;
      busy        <= 1'b0;
      done        <= 1'b0;
      ecx_out     <= ADDR_ZERO;
      esi_out     <= ADDR_ZERO;
      edi_out     <= ADDR_ZERO;
    end else begin
      is_movs_r   <= is_movs_nxt_s;
      rep_r       <= rep_nxt_s;
      df_r        <= df_nxt_s;
      size_r      <= size_nxt_s;
      ecx_r       <= ecx_nxt_s;
      esi_r       <= esi_nxt_s;
      edi_r       <= edi_nxt_s;
      eax_r       <= eax_nxt_s;
      rd_data_r   <= rd_data_nxt_s;
      mem_rd_req  <= (state_nxt_s == ST_READ);
      mem_rd_addr <= esi_nxt_s;
      mem_wr_req  <= (state_nxt_s == ST_WRITE);
      mem_wr_addr <= edi_nxt_s;
      mem_wr_data <= is_movs_nxt_s ? rd_data_nxt_s : eax_nxt_s;
      mem_size    <= size_nxt_s;
      busy        <= (state_nxt_s != ST_IDLE);
      done        <= (state_nxt_s == ST_DONE);
      ecx_out     <= ecx_nxt_s;
      esi_out     <= esi_nxt_s;
      edi_out     <= edi_nxt_s;
    end
  end

endmodule

// File: tb/tb_string_op_seq.sv
// Randomized self-checking bench for string_op_seq with a transaction-level model.
module tb_string_op_seq;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, is_movs = 1'b0, rep_en = 1'b0, df_in = 1'b0, flush = 1'b0;
  logic [1:0]    op_size = 2'b00;
  logic [AW-1:0] ecx_in = '0, esi_in = '0, edi_in = '0;
  logic [DW-1:0] eax_in = '0;
  logic          mem_rd_ack = 1'b0, mem_wr_ack = 1'b0;
  logic [DW-1:0] mem_rd_data = '0;
  logic          mem_rd_req, mem_wr_req, busy, done;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr, ecx_out, esi_out, edi_out;
  logic [DW-1:0] mem_wr_data;
  logic [1:0]    mem_size;

  string_op_seq #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .is_movs(is_movs), .rep_en(rep_en),
    .op_size(op_size), .DF_in(df_in), .ecx_in(ecx_in), .esi_in(esi_in),
    .edi_in(edi_in), .eax_in(eax_in), .flush(flush),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ack(mem_rd_ack),
    .mem_rd_data(mem_rd_data), .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_ack(mem_wr_ack), .mem_size(mem_size),
    .busy(busy), .done(done), .ecx_out(ecx_out), .esi_out(esi_out), .edi_out(edi_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction model: expected access streams, final registers, done cycle.
  bit            active = 1'b0, aborted = 1'b0, hold_off = 1'b0, saw_done = 1'b0;
  logic [1:0]    size_m;
  logic [AW-1:0] exp_rd_q[$], exp_wr_q[$];
  logic [DW-1:0] data_q[$];
  int            rd_dly_q[$], wr_dly_q[$];
  int            rd_cnt, wr_cnt, wr_hs, flush_idx = -1;
  int            start_cyc, exp_done_cyc, last_lat;
  logic [AW-1:0] exp_ecx, exp_esi, exp_edi, last_ecx, last_esi, last_edi, first_wr_addr;
  logic [DW-1:0] first_wr_data;

  // Compare process plus ack/data/flush driver, all on the falling edge
  always @(negedge clk) begin
    mem_rd_ack = 1'b0;
    mem_wr_ack = 1'b0;
    flush      = 1'b0;
    if (active && aborted) begin
      check("flush_busy", busy, 0);
      check("flush_rd_req", mem_rd_req, 0);
      check("flush_wr_req", mem_wr_req, 0);
      check("flush_done", done, 0);
      active  = 1'b0;
      aborted = 1'b0;
    end else if (active && cyc > start_cyc) begin
      check("busy", busy, 1);
      if (mem_rd_req) begin
        if (exp_rd_q.size() == 0) begin
          check("rd_req_extra", mem_rd_req, 0);
        end else begin
          check("rd_addr", mem_rd_addr, exp_rd_q[0]);
          check("rd_size", mem_size, size_m);
          if (rd_cnt >= rd_dly_q[0]) begin
            mem_rd_ack  = 1'b1;
            mem_rd_data = $urandom;
            data_q.push_back(mem_rd_data);
            void'(exp_rd_q.pop_front());
            void'(rd_dly_q.pop_front());
            rd_cnt = 0;
          end else begin
            rd_cnt++;
          end
        end
      end
      if (mem_wr_req) begin
        if (exp_wr_q.size() == 0 || data_q.size() == 0) begin
          check("wr_req_extra", mem_wr_req, 0);
        end else begin
          check("wr_addr", mem_wr_addr, exp_wr_q[0]);
          check("wr_data", mem_wr_data, data_q[0]);
          check("wr_size", mem_size, size_m);
          if (wr_hs == flush_idx) begin
            flush   = 1'b1;
            aborted = 1'b1;
          end else if (wr_cnt >= wr_dly_q[0]) begin
            mem_wr_ack = 1'b1;
            if (wr_hs == 0) begin
              first_wr_addr = mem_wr_addr;
              first_wr_data = mem_wr_data;
            end
            void'(exp_wr_q.pop_front());
            void'(data_q.pop_front());
            void'(wr_dly_q.pop_front());
            wr_cnt = 0;
            wr_hs++;
          end else begin
            wr_cnt++;
          end
        end
      end
      if (done) begin
        check("done_cycle", cyc, exp_done_cyc);
        check("ecx_out", ecx_out, exp_ecx);
        check("esi_out", esi_out, exp_esi);
        check("edi_out", edi_out, exp_edi);
        check("writes_left", exp_wr_q.size(), 0);
        last_lat = cyc - start_cyc;
        last_ecx = ecx_out;
        last_esi = esi_out;
        last_edi = edi_out;
        saw_done = 1'b1;
        active   = 1'b0;
      end else if (cyc > exp_done_cyc) begin
        check("done_late", done, 1);
        active = 1'b0;
      end
    end else if (!active && !hold_off) begin
      check("idle_rd_req", mem_rd_req, 0);
      check("idle_wr_req", mem_wr_req, 0);
      check("idle_done", done, 0);
    end
  end

  task automatic run_txn(input bit mv, input bit rp, input logic [1:0] sz, input bit d,
                         input logic [AW-1:0] c, input logic [AW-1:0] s, input logic [AW-1:0] e,
                         input logic [DW-1:0] a, input int rdly, input int wdly,
                         input int fl_idx, input bit junk);
    int iters, lat, step, dr, dw;
    logic [AW-1:0] off;
    @(negedge clk);
    iters = rp ? int'(c) : 1;
    step  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    exp_rd_q.delete(); exp_wr_q.delete(); data_q.delete();
    rd_dly_q.delete(); wr_dly_q.delete();
    lat = 1;
    for (int i = 0; i < iters; i++) begin
      off = AW'(i * step);
      dr  = (rdly < 0) ? int'($urandom_range(0, 3)) : rdly;
      dw  = (wdly < 0) ? int'($urandom_range(0, 3)) : wdly;
      if (mv) begin
        exp_rd_q.push_back(d ? s - off : s + off);
        rd_dly_q.push_back(dr);
        lat += 1 + dr;
      end else begin
        data_q.push_back(a);
      end
      exp_wr_q.push_back(d ? e - off : e + off);
      wr_dly_q.push_back(dw);
      lat += 2 + dw;
    end
    off     = AW'(iters * step);
    exp_esi = mv ? (d ? s - off : s + off) : s;
    exp_edi = d ? e - off : e + off;
    exp_ecx = rp ? '0 : c;
    start_cyc    = cyc;
    exp_done_cyc = (fl_idx >= 0) ? cyc + 100000 : cyc + lat;
    rd_cnt = 0; wr_cnt = 0; wr_hs = 0; flush_idx = fl_idx;
    aborted = 1'b0; saw_done = 1'b0; last_lat = -1; size_m = sz;
    is_movs = mv; rep_en = rp; op_size = sz; df_in = d;
    ecx_in = c; esi_in = s; edi_in = e; eax_in = a;
    start = 1'b1;
    active = 1'b1;
    @(negedge clk);
    if (junk) begin
      is_movs = ~mv; rep_en = 1'b1; op_size = 2'($urandom); df_in = ~d;
      ecx_in = $urandom; esi_in = $urandom; edi_in = $urandom; eax_in = $urandom;
    end else begin
      start = 1'b0;
    end
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 400 && active; k++) @(negedge clk);
    if (active) begin
      check("txn_stuck", active, 0);
      active = 1'b0;
    end
  endtask

  initial begin
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_reqs", {mem_rd_req, mem_wr_req}, 0);
    check("rst_addrs", {mem_rd_addr, mem_wr_addr}, 0);
    check("rst_outs", {ecx_out, esi_out, edi_out, mem_wr_data, mem_size}, 0);
    @(negedge clk);
    rst = 1'b0;

    run_txn(1'b0, 1'b0, 2'b10, 1'b0, 32'd7, 32'h0, 32'h1000, 32'hDEADBEEF, 0, 0, -1, 1'b0);
    check("stos_lat", last_lat, 3);
    check("stos_wr_addr", first_wr_addr, 32'h1000);
    check("stos_wr_data", first_wr_data, 32'hDEADBEEF);
    check("stos_edi_out", last_edi, 32'h1004);

    run_txn(1'b1, 1'b1, 2'b01, 1'b1, 32'd3, 32'h2006, 32'h3006, 32'h0, 0, 0, -1, 1'b0);
    check("repmovs_lat", last_lat, 10);
    check("repmovs_ecx", last_ecx, 32'h0);
    check("repmovs_esi", last_esi, 32'h2000);
    check("repmovs_edi", last_edi, 32'h3000);

    run_txn(1'b0, 1'b1, 2'b10, 1'b0, 32'd0, 32'h4444, 32'h5555, 32'h1234, 0, 0, -1, 1'b1);
    check("rep0_lat", last_lat, 1);
    check("rep0_writes", wr_hs, 0);
    check("rep0_edi", last_edi, 32'h5555);
    check("rep0_esi", last_esi, 32'h4444);

    run_txn(1'b1, 1'b0, 2'b10, 1'b0, 32'd9, 32'h100, 32'h200, 32'h0, 2, 1, -1, 1'b0);
    check("slowack_lat", last_lat, 7);

    run_txn(1'b1, 1'b1, 2'b00, 1'b0, 32'd5, 32'h600, 32'h700, 32'h0, 0, 0, 1, 1'b0);
    check("flush_no_done", saw_done, 0);
    run_txn(1'b0, 1'b0, 2'b10, 1'b0, 32'd1, 32'h0, 32'h80, 32'hCAFE, 0, 0, -1, 1'b0);
    check("after_flush_lat", last_lat, 3);

    run_txn(1'b0, 1'b0, 2'b10, 1'b1, 32'd1, 32'h0, 32'h2, 32'h55, -1, -1, -1, 1'b0);
    check("wrap_edi", last_edi, 32'hFFFFFFFE);

    // Asynchronous reset while a read is outstanding
    hold_off = 1'b1;
    @(negedge clk);
    is_movs = 1'b1; rep_en = 1'b0; op_size = 2'b10; df_in = 1'b0;
    ecx_in = 32'd4; esi_in = 32'h5000; edi_in = 32'h6000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("pre_rst_rd_req", mem_rd_req, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_rd_req", mem_rd_req, 0);
    check("midrst_rd_addr", mem_rd_addr, 0);
    check("midrst_busy", busy, 0);
    check("midrst_outs", {ecx_out, esi_out, edi_out, mem_size}, 0);
    @(negedge clk);
    rst = 1'b0;
    hold_off = 1'b0;

    for (int t = 0; t < 40; t++) begin
      run_txn(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
              AW'($urandom_range(0, 6)), $urandom, $urandom, $urandom, -1, -1, -1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
